// File: rtl/rtc_bus_writer.sv
// rtc_bus_writer: runs one address-then-data write cycle on the RTC multiplexed AD bus per accepted strobe.
//
// Ports:
//   clk_i       system clock, all logic on the rising edge
//   rst_ni      synchronous reset, active low
//   write_i     one-cycle write request strobe
//   addr_i      RTC register address, latched on accept
//   data_i      value to write, latched on accept
//   busy_o      high from the accept edge through the DONE cycle
//   done_o      one-cycle completion pulse
//   cs_n_o      RTC chip select, active low
//   wr_n_o      RTC write strobe, active low
//   rd_n_o      RTC read strobe, held high
//   ad_o        bus qualifier: 0 address phase, 1 data phase
//   bus_oe_o    tristate enable for the AD pins
//   bus_out_o   value driven onto the AD pins
module rtc_bus_writer #(
    parameter int T_PHASE = 4,
    parameter int CW      = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       write_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       cs_n_o,
    output logic       wr_n_o,
    output logic       rd_n_o,
    output logic       ad_o,
    output logic       bus_oe_o,
    output logic [7:0] bus_out_o
);
    // Enum order matters: the six bus sub-phases are consecutive so that
    // advancing a phase is a plain increment.
    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_WR, A_HOLD, D_SETUP, D_WR, D_HOLD, DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      addr_q, addr_d, data_q, data_d;
    logic            last, in_addr, in_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last    = cnt_q == CW'(T_PHASE - 1);
        case (state_q)
            IDLE: begin
                if (write_i) begin
                    state_d = A_SETUP;
                    cnt_d   = '0;
                    addr_d  = addr_i;
                    data_d  = data_i;
                end
            end
            DONE:    state_d = IDLE;
            default: begin
                state_d = last ? state_e'(state_q + 3'd1) : state_q;
                cnt_d   = last ? '0 : cnt_q + 1'b1;
            end
        endcase
        in_addr = state_d inside {A_SETUP, A_WR, A_HOLD};
        in_data = state_d inside {D_SETUP, D_WR, D_HOLD};
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            cs_n_o    <= 1'b1;
            wr_n_o    <= 1'b1;
            rd_n_o    <= 1'b1;
            ad_o      <= 1'b1;
            bus_oe_o  <= 1'b0;
            bus_out_o <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_o    <= state_d != IDLE;
            done_o    <= state_d == DONE;
            cs_n_o    <= !(in_addr || in_data);
            wr_n_o    <= !(state_d inside {A_WR, D_WR});
            rd_n_o    <= 1'b1;
            ad_o      <= !in_addr;
            bus_oe_o  <= in_addr || in_data;
            bus_out_o <= in_addr ? addr_d : (in_data ? data_d : 8'h00);
        end
    end
endmodule

// File: doc/rtc_bus_writer.md
Name: rtc_bus_writer

Overview:
- Consumes the single-cycle `write` strobe from the falling-edge write generator.
- Runs one complete write transaction on the RTC chip's multiplexed address/data bus: an address phase, then a data phase.
- Uses Intel-style CS/WR/AD strobes with programmable phase timing.
- Sits between the edge-detector strobe and the RTC pins; reports busy/done back to the control FSM.

Parameters:
- T_PHASE, 4: clock cycles spent in each of the six bus sub-phases; legal range 1..255.
- CW, 8: width of the internal phase counter; must satisfy 2^CW > T_PHASE.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active low.
- write  input  1  one-cycle write request strobe from the edge detector.
- addr  input  8  RTC register address; sampled when a request is accepted.
- data  input  8  value to write; sampled when a request is accepted.
- busy  output  1  high from the accept edge through the DONE cycle inclusive.
- done  output  1  one-cycle pulse when the transaction completes.
- cs_n  output  1  RTC chip select, active low.
- wr_n  output  1  RTC write strobe, active low.
- rd_n  output  1  RTC read strobe; held at 1.
- ad  output  1  bus qualifier: 0 = address phase, 1 = data phase.
- bus_oe  output  1  tristate enable for the shared AD pins.
- bus_out  output  8  value driven onto the AD pins.

Behaviour:
- All outputs are registered and update on the same edge as the state.
- Reset (rst_n=0 at a rising edge) is synchronous and overrides everything.
  - Reset puts the block in IDLE with cs_n=1, wr_n=1, rd_n=1, ad=1, bus_oe=0, bus_out=0, busy=0, done=0, counter=0, latched addr/data=0.
  - Reset mid-transaction aborts immediately; there is no completion pulse.
- States: IDLE, A_SETUP, A_WR, A_HOLD, D_SETUP, D_WR, D_HOLD, DONE.
- Accept: in IDLE, write=1 at an edge latches addr_q<=addr and data_q<=data, enters A_SETUP, sets busy=1 and clears the counter. Latency from strobe to cs_n=0 is 1 cycle.
- Each of A_SETUP..D_HOLD lasts exactly T_PHASE cycles.
  - The counter runs 0..T_PHASE-1.
  - At T_PHASE-1 the FSM advances to the next state and the counter returns to 0.
- Output values by state:
  - A_SETUP: cs_n=0, ad=0, bus_oe=1, bus_out=addr_q, wr_n=1.
  - A_WR: as A_SETUP, but wr_n=0.
  - A_HOLD: as A_SETUP, with wr_n=1.
  - D_SETUP: cs_n=0, ad=1, bus_oe=1, bus_out=data_q, wr_n=1.
  - D_WR: as D_SETUP, but wr_n=0.
  - D_HOLD: as D_SETUP, with wr_n=1.
  - DONE: lasts 1 cycle with cs_n=1, wr_n=1, ad=1, bus_oe=0, bus_out=0, done=1, busy=1. Then returns to IDLE: busy=0, done=0.
- Busy time for one transaction is 6*T_PHASE+1 cycles.
- wr_n is low for exactly T_PHASE cycles per phase, two windows per transaction.
- wr_n never goes low while ad changes, and bus_out never changes while wr_n=0.
- A write strobe arriving while busy=1 (including the DONE cycle) is ignored, not queued.
- addr/data changes after accept have no effect, because the latched copies drive the bus.
- write held high for several cycles in IDLE starts exactly one transaction. A new transaction is accepted only once the FSM is back in IDLE.
- T_PHASE=1 is legal: each sub-phase lasts one cycle, for 7 busy cycles total.

Test Plan:
1. Reset: rst_n=0 for 3 cycles, then release -> cs_n=1, wr_n=1, rd_n=1, ad=1, bus_oe=0, busy=0, done=0, with no activity.
2. Single write, T_PHASE=2: write pulse with addr=0x21, data=0x45 ->
   - cs_n low the next cycle.
   - bus_out=0x21 with ad=0 for 6 cycles; wr_n low in cycles 3-4 of that window.
   - bus_out=0x45 with ad=1 for 6 cycles; wr_n low in cycles 3-4 of that window.
   - done=1 on cycle 13; busy high exactly 13 cycles.
3. Strobe during busy: second write (addr=0x22) at cycle 5 and again at the DONE cycle -> ignored; only 0x21/0x45 appear, with one done pulse.
4. Input change after accept: change addr to 0xFF and data to 0x00 one cycle after accept -> bus still shows 0x21 then 0x45.
5. Reset mid-operation: rst_n=0 during D_WR -> next edge gives cs_n=1, wr_n=1, bus_oe=0, busy=0, with no done pulse. A new write afterwards completes normally.
6. Back-to-back, T_PHASE=1: a write is issued on the first IDLE cycle after each done (×2, addr 0x10/0x11, data 0xA5/0x5A) -> two transactions, 7 busy cycles each, correct latched values.
